// File: rtl/io_bl_wl_prog_ctrl.sv
// Bit-line / word-line programming controller for an IO tile memory.
// Each configuration word is accepted in LOAD and driven onto the bit lines.
// The word is then written with a SETUP / WRITE / HOLD word-line pulse,
// one row at a time. A cfg_last mismatch parks the controller in ERR until reset.
// Optional macro IO_PROG_PARITY_EN adds the cfg_parity input and an even-parity check.
module io_bl_wl_prog_ctrl #(
  parameter int unsigned NUM_WL = 8,
  parameter int unsigned NUM_BL = 8
) (
  input  logic              prog_clk,
  input  logic              global_resetn,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [0:NUM_BL-1] cfg_data,
  input  logic              cfg_last,
`ifdef IO_PROG_PARITY_EN
  input  logic              cfg_parity,
`endif
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned RowW = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_WL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StWrite,
    StHold,
    StDone,
    StErr
  } state_e;

  state_e            state_q;
  logic [RowW-1:0]   row_q;
  logic [0:NUM_WL-1] wl_row;
  logic              last_ok;
  logic              parity_ok;
  logic              word_ok;

  // One-hot word-line pattern for the current row.
  always_comb begin
    wl_row = '0;
    for (int i = 0; i < int'(NUM_WL); i++) begin
      wl_row[i] = (row_q == RowW'(i));
    end
  end

  // Accept a word only if cfg_last marks exactly the final row (and parity matches).
  always_comb begin
    last_ok = (cfg_last == (row_q == LastRow));
`ifdef IO_PROG_PARITY_EN
    parity_ok = ((^cfg_data) == cfg_parity);
`else
    parity_ok = 1'b1;
`endif
    word_ok = last_ok && parity_ok;
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge prog_clk) begin
    if (!global_resetn) begin
      state_q   <= StIdle;
      row_q     <= '0;
      bl        <= '0;
      wl        <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLoad;
            row_q     <= '0;
            err       <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StLoad: begin
          if (cfg_valid && cfg_ready) begin
            cfg_ready <= 1'b0;
            if (word_ok) begin
              bl      <= cfg_data;
              state_q <= StSetup;
            end else begin
              bl      <= '0;
              err     <= 1'b1;
              state_q <= StErr;
            end
          end
        end
        StSetup: begin
          wl      <= wl_row;
          state_q <= StWrite;
        end
        StWrite: begin
          wl      <= '0;
          state_q <= StHold;
        end
        StHold: begin
          if (row_q == LastRow) begin
            bl      <= '0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            row_q     <= row_q + RowW'(1);
            cfg_ready <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StErr: begin
          // Terminal until reset; start is ignored here.
          err       <= 1'b1;
          bl        <= '0;
          wl        <= '0;
          cfg_ready <= 1'b0;
        end
        default: begin
          bl        <= '0;
          wl        <= '0;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bl_wl_prog_ctrl.sv
// Self-checking bench for io_bl_wl_prog_ctrl.
// Each pass is planned as a timeline before it runs. Row r's LOAD window opens at lo[r].
// The handshake lands at hs[r] = lo[r] + stall[r], followed by SETUP, WRITE and HOLD.
// Every cycle's outputs are then predicted from that timeline.
module tb_io_bl_wl_prog_ctrl;

  localparam int unsigned NWl = 8;
  localparam int unsigned NBl = 8;

  logic           prog_clk = 1'b0;
  logic           global_resetn;
  logic           start;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [0:NBl-1] cfg_data;
  logic           cfg_last;
`ifdef IO_PROG_PARITY_EN
  logic           cfg_parity;
`endif
  logic [0:NBl-1] bl;
  logic [0:NWl-1] wl;
  logic           busy;
  logic           done;
  logic           err;

  always #5 prog_clk = ~prog_clk;

  io_bl_wl_prog_ctrl #(
    .NUM_WL(NWl),
    .NUM_BL(NBl)
  ) dut (
    .prog_clk     (prog_clk),
    .global_resetn(global_resetn),
    .start        (start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
`ifdef IO_PROG_PARITY_EN
    .cfg_parity   (cfg_parity),
`endif
    .bl           (bl),
    .wl           (wl),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pass_id  = 0;

  // Plan for the next pass.
  logic [NBl-1:0] data [NWl];
  int             stall [NWl];
  int             last_err_row;
  int             par_err_row;
  int             rst_row;
  bit             rnd_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s pass=%0d cyc=%0d got=%0h exp=%0h", tag, pass_id, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [NBl-1:0] e_bl, input logic [0:NWl-1] e_wl,
                               input bit e_ready, input bit e_busy, input bit e_done,
                               input bit e_err);
    check("bl", 32'(bl), 32'(e_bl));
    check("wl", 32'(wl), 32'(e_wl));
    check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
  endtask

  task automatic clear_plan();
    for (int r = 0; r < int'(NWl); r++) begin
      data[r]  = NBl'(r + 1);
      stall[r] = 0;
    end
    last_err_row = -1;
    par_err_row  = -1;
    rst_row      = -1;
    rnd_start    = 1'b0;
  endtask

  task automatic run_pass();
    int lo [NWl];
    int hs [NWl];
    int fault_row;
    int done_c;
    int end_c;
    int busy_end;
    logic [NBl-1:0] e_bl;
    logic [0:NWl-1] e_wl;
    bit e_ready, e_busy, e_done, e_err;
    int win;

    pass_id++;
    lo[0] = 1;
    for (int r = 0; r < int'(NWl); r++) begin
      hs[r] = lo[r] + stall[r];
      if (r + 1 < int'(NWl)) lo[r+1] = hs[r] + 4;
    end
    done_c = hs[NWl-1] + 4;

    fault_row = last_err_row;
    if (par_err_row >= 0 && (fault_row < 0 || par_err_row < fault_row)) fault_row = par_err_row;

    if (fault_row >= 0) begin
      end_c    = hs[fault_row] + 6;
      busy_end = end_c + 1;
    end else if (rst_row >= 0) begin
      end_c    = hs[rst_row] + 4;
      busy_end = hs[rst_row] + 3;
    end else begin
      end_c    = done_c + 1;
      busy_end = done_c + 1;
    end

    for (int c = 0; c <= end_c; c++) begin
      @(posedge prog_clk);
      #1;
      cyc = c;

      e_bl = '0; e_wl = '0; e_ready = 0; e_busy = 0; e_done = 0; e_err = 0;
      if (c == 0) begin
        // Idle before start.
      end else if (fault_row >= 0 && c > hs[fault_row]) begin
        e_busy = 1; e_err = 1;
      end else if (rst_row >= 0 && c > hs[rst_row] + 2) begin
        // Reset took effect.
      end else if (c >= done_c) begin
        e_done = (c == done_c);
        e_busy = (c == done_c);
      end else begin
        e_busy = 1;
        for (int r = 0; r < int'(NWl); r++) begin
          if (c >= lo[r] && c <= hs[r]) begin
            e_ready = 1;
            e_bl    = (r == 0) ? '0 : data[r-1];
          end else if (c >= hs[r] + 1 && c <= hs[r] + 3) begin
            e_bl = data[r];
            if (c == hs[r] + 2) e_wl[r] = 1'b1;
          end
        end
      end
      check_outputs(e_bl, e_wl, e_ready, e_busy, e_done, e_err);

      // Drive this cycle's inputs; outside LOAD windows everything is noise.
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = NBl'($urandom);
      cfg_last  = 1'($urandom_range(0, 1));
`ifdef IO_PROG_PARITY_EN
      cfg_parity = 1'($urandom_range(0, 1));
`endif
      win = -1;
      for (int r = 0; r < int'(NWl); r++) begin
        if (c >= lo[r] && c <= hs[r] && (fault_row < 0 || r <= fault_row)) win = r;
      end
      if (win >= 0 && !(rst_row >= 0 && c > hs[rst_row] + 2)) begin
        cfg_valid = (c == hs[win]);
        if (c == hs[win]) begin
          cfg_data = data[win];
          cfg_last = (win == int'(NWl) - 1) ^ (win == last_err_row);
`ifdef IO_PROG_PARITY_EN
          cfg_parity = (^data[win]) ^ (win == par_err_row);
`endif
        end
      end
      if (c == 0) start = 1'b1;
      else start = rnd_start && (c < busy_end) && ($urandom_range(0, 3) == 0);
      global_resetn = !(rst_row >= 0 && c == hs[rst_row] + 2);
    end

    start         = 1'b0;
    cfg_valid     = 1'b0;
    global_resetn = 1'b1;

    if (fault_row >= 0) begin
      @(posedge prog_clk);
      #1;
      global_resetn = 1'b0;
      @(posedge prog_clk);
      #1;
      global_resetn = 1'b1;
      cyc = -1;
      check_outputs('0, '0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    global_resetn = 1'b0;
    start         = 1'b0;
    cfg_valid     = 1'b0;
    cfg_data      = '0;
    cfg_last      = 1'b0;
`ifdef IO_PROG_PARITY_EN
    cfg_parity    = 1'b0;
`endif
    repeat (2) @(posedge prog_clk);
    #1;
    cyc = -1;
    check_outputs('0, '0, 0, 0, 0, 0);
    global_resetn = 1'b1;

    // Nominal: words r+1, no stalls, done at cycle 33.
    clear_plan();
    run_pass();

    // Backpressure before row 3.
    clear_plan();
    stall[3] = 5;
    run_pass();

    // Early cfg_last on row 2.
    clear_plan();
    last_err_row = 2;
    run_pass();

    // Reset during WRITE of row 4, then a clean pass from row 0.
    clear_plan();
    rst_row = 4;
    run_pass();
    clear_plan();
    run_pass();

    // start pulses while busy are ignored.
    clear_plan();
    rnd_start = 1'b1;
    stall[1]  = 2;
    run_pass();

`ifdef IO_PROG_PARITY_EN
    clear_plan();
    data[0]     = NBl'(8'h03);
    par_err_row = 0;
    run_pass();
    clear_plan();
    data[0] = NBl'(8'h03);
    run_pass();
`endif

    // Randomized passes.
    for (int p = 0; p < 10; p++) begin
      int kind;
      clear_plan();
      for (int r = 0; r < int'(NWl); r++) begin
        data[r]  = NBl'($urandom);
        stall[r] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      rnd_start = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      if (kind == 1) last_err_row = int'($urandom_range(0, NWl - 1));
      if (kind == 2) rst_row = int'($urandom_range(0, NWl - 1));
`ifdef IO_PROG_PARITY_EN
      if (kind == 3) par_err_row = int'($urandom_range(0, NWl - 1));
`endif
      run_pass();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
